alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage consumer of the ALU_CONTROL code produced by the decode-stage ALU decoder.
//  Accepts {ALU_CONTROL, SRC_A, SRC_B} over a valid/ready handshake and computes the result.
//  Single-cycle ops: ADD, SUB, AND, OR, XOR. Iterative ops: SLL, SRL, SRA at one bit per cycle.
//  Returns RESULT and ZERO over a second valid/ready handshake.
// PARAMETERS
//  XLEN   32  datapath width; must be a power of 2 and >= 8
//  SHW    $clog2(XLEN)  shift-amount width; derived, not overridden
// PORTS
//  clk          in   1     clock, rising edge
//  reset        in   1     asynchronous, active-high reset
//  IN_VALID     in   1     operation request valid
//  IN_READY     out  1     unit can accept a request
//  ALU_CONTROL  in   3     op code; Constants.v `ALU_ADD/SUB/AND/OR/XOR/SLL/SRL/SRA
//  SRC_A        in   XLEN  operand A; shift source for shift ops
//  SRC_B        in   XLEN  operand B; SRC_B[SHW-1:0] is the shift amount
//  OUT_VALID    out  1     RESULT/ZERO valid
//  OUT_READY    in   1     consumer takes the result
//  RESULT       out  XLEN  operation result
//  ZERO         out  1     1 when RESULT == 0
// BEHAVIOUR
//  Clock/reset: one clock, clk. reset is asynchronous and active-high.
//  Reset: state IDLE; IN_READY=1; OUT_VALID=0; RESULT=0; ZERO=1; shift counter=0.
//  FSM states:
//   IDLE:  IN_READY=1. Accept on IN_VALID&IN_READY; capture the op code and operands.
//          Logic/arith op -> DONE. Shift op with amount 0 -> DONE. Other shift op -> SHIFT.
//   SHIFT: IN_READY=0. Each cycle shifts the accumulator by 1 and decrements the counter.
//          Enter DONE on the cycle the counter reaches 0.
//   DONE:  OUT_VALID=1, RESULT held stable. On OUT_READY: back to IDLE.
//  Latency (accept edge -> OUT_VALID):
//   Logic/arith op, or shift with amount 0: 1 cycle.
//   Shift with amount N>0: N+1 cycles.
//  No back-to-back accept: IN_READY=0 in SHIFT and DONE; throughput is 1 op per 2 cycles minimum.
//  Arithmetic: modulo 2^XLEN, carry/overflow discarded. SUB = A + ~B + 1.
//  Shifts: SRA replicates SRC_A[XLEN-1]. SRL and SLL shift in zeros.
//  Shift amount: only SRC_B[SHW-1:0] is used; upper bits of SRC_B are ignored.
//  Unknown ALU_CONTROL code: treated as ADD (matches the decoder default).
//  ZERO: registered together with RESULT; reflects the final value, never an intermediate shift value.
//  Handshake rules:
//   OUT_VALID, once high, stays high with RESULT unchanged until OUT_READY is sampled high.
//   Inputs are don't-care outside the accept cycle; a change in SRC_A/SRC_B during SHIFT has no effect.
//  reset mid-operation (SHIFT or DONE): immediate return to reset values; the pending result is lost.
// CONFIGURATION
//  ALU_EXEC_FAST_SHIFT_EN defined:
//   Shifts use a single-cycle barrel shifter. All ops have 1-cycle latency.
//   SHIFT state and shift counter are not built.
//  ALU_EXEC_FAST_SHIFT_EN undefined:
//   Iterative shifter as above. Functional results are identical in both builds; only latency differs.
// TESTING
//  T1 Reset: assert reset mid-SHIFT (SLL, amount 20, cycle 5) -> next edge IN_READY=1, OUT_VALID=0, RESULT=0, ZERO=1.
//  T2 ADD/SUB: ADD 0x7FFFFFFF+1 -> 0x80000000, ZERO=0, 1 cycle; SUB 5-5 -> 0x0, ZERO=1.
//  T3 Logic: AND/OR/XOR of 0xF0F0F0F0 and 0xFF00FF00 -> 0xF000F000 / 0xFFF0FFF0 / 0x0FF00FF0.
//  T4 Shifts:
//   SRA 0x80000000 by 4 -> 0xF8000000 after 5 cycles.
//   SRL same operands -> 0x08000000.
//   SLL 1 by SRC_B=0x21 -> 0x2, shift amount 1.
//   Any shift by 0 -> result equals SRC_A after 1 cycle.
//  T5 Backpressure:
//   Hold OUT_READY=0 for 10 cycles -> OUT_VALID=1, RESULT stable, IN_READY=0 throughout.
//   Release OUT_READY -> IDLE next cycle.
//  T6 Fast-shift build (macro defined): SLL 1 by 31 -> 0x80000000 with 1-cycle latency; rerun T2-T5 results.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked execute-stage ALU; shifts iterate one bit per cycle
// unless ALU_EXEC_FAST_SHIFT_EN selects a single-cycle barrel shifter.
module alu_exec_unit #(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [2:0]      ALU_CONTROL,
    input  logic [XLEN-1:0] SRC_A,
    input  logic [XLEN-1:0] SRC_B,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] RESULT,
    output logic            ZERO
);
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SRA = 3'd7;
`ifdef ALU_EXEC_FAST_SHIFT_EN
    typedef enum logic {IDLE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif
    state_t state, nxt;
    logic [XLEN-1:0] acc, res_c;
    logic [SHW-1:0] amt;
    logic zero_q, accept;
    assign amt = SRC_B[SHW-1:0];
    assign accept = IN_VALID && state == IDLE;
    assign RESULT = acc;
    assign ZERO = zero_q;
    always_comb begin
        case (ALU_CONTROL)
            ALU_SUB: res_c = SRC_A + ~SRC_B + XLEN'(1);
            ALU_AND: res_c = SRC_A & SRC_B;
            ALU_OR:  res_c = SRC_A | SRC_B;
            ALU_XOR: res_c = SRC_A ^ SRC_B;
`ifdef ALU_EXEC_FAST_SHIFT_EN
            ALU_SLL: res_c = SRC_A << amt;
            ALU_SRL: res_c = SRC_A >> amt;
            ALU_SRA: res_c = XLEN'($signed(SRC_A) >>> amt);
`else
            // shift source is loaded as-is and stepped in SHIFT
            ALU_SLL, ALU_SRL, ALU_SRA: res_c = SRC_A;
`endif
            default: res_c = SRC_A + SRC_B;
        endcase
    end
`ifndef ALU_EXEC_FAST_SHIFT_EN
    logic [2:0] op;
    logic [SHW-1:0] cnt;
    logic [XLEN-1:0] step_c;
    logic is_shift;
    assign is_shift = ALU_CONTROL == ALU_SLL || ALU_CONTROL == ALU_SRL || ALU_CONTROL == ALU_SRA;
    assign step_c = op == ALU_SLL ? {acc[XLEN-2:0], 1'b0} : {op == ALU_SRA && acc[XLEN-1], acc[XLEN-1:1]};
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
`ifdef ALU_EXEC_FAST_SHIFT_EN
                if (IN_VALID) nxt = DONE;
`else
                if (IN_VALID) nxt = (is_shift && amt != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                if (cnt == SHW'(1)) nxt = DONE;
`endif
            end
            DONE: begin
                if (OUT_READY) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        IN_READY = state == IDLE;
        OUT_VALID = state == DONE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            zero_q <= 1'b1;
`ifndef ALU_EXEC_FAST_SHIFT_EN
            op <= ALU_ADD;
            cnt <= '0;
`endif
        end else if (accept) begin
            acc <= res_c;
            // ZERO only tracks final values, so skip it when a shift is pending
            if (nxt == DONE) zero_q <= res_c == '0;
`ifndef ALU_EXEC_FAST_SHIFT_EN
            op <= ALU_CONTROL;
            cnt <= is_shift ? amt : '0;
        end else if (state == SHIFT) begin
            acc <= step_c;
            cnt <= cnt - SHW'(1);
            if (cnt == SHW'(1)) zero_q <= step_c == '0;
`endif
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against a behavioural model.
module tb_alu_exec_unit;
    localparam int XLEN = 32;
    logic clk = 1'b0;
    logic reset, IN_VALID, IN_READY, OUT_VALID, OUT_READY, ZERO;
    logic [2:0] ALU_CONTROL;
    logic [XLEN-1:0] SRC_A, SRC_B, RESULT;
    int n_checks = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .ALU_CONTROL(ALU_CONTROL), .SRC_A(SRC_A), .SRC_B(SRC_B),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .RESULT(RESULT), .ZERO(ZERO)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int amt;
        logic [63:0] ext;
        amt = int'(b[4:0]);
        ext = {{32{a[31]}}, a};
        case (op)
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << amt;
            3'd6: return a >> amt;
            3'd7: begin
                ext = ext >> amt;
                return ext[31:0];
            end
            default: return a + b;
        endcase
    endfunction
    function automatic int latency(input logic [2:0] op, input logic [31:0] b);
`ifdef ALU_EXEC_FAST_SHIFT_EN
        return 1;
`else
        return (op >= 3'd5 && b[4:0] != 5'd0) ? int'(b[4:0]) + 1 : 1;
`endif
    endfunction
    task automatic wait_ready();
        int cyc = 0;
        while (!IN_READY && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("in_ready_idle", IN_READY, 1);
    endtask
    task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        wait_ready();
        IN_VALID = 1'b1;
        ALU_CONTROL = op;
        SRC_A = a;
        SRC_B = b;
        @(posedge clk);
        #1;
        IN_VALID = 1'b0;
        ALU_CONTROL = 3'($urandom);
        SRC_A = $urandom;
        SRC_B = $urandom;
    endtask
    task automatic exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        int cyc;
        logic [31:0] exp;
        exp = model(op, a, b);
        start(op, a, b);
        cyc = 1;
        while (!OUT_VALID && cyc < 100) begin
            check("busy_in_ready", IN_READY, 0);
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", cyc, latency(op, b));
        check("result", RESULT, exp);
        check("zero", ZERO, exp == 0);
        check("done_in_ready", IN_READY, 0);
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("hold_valid", OUT_VALID, 1);
            check("hold_result", RESULT, exp);
            check("hold_in_ready", IN_READY, 0);
        end
        OUT_READY = 1'b1;
        @(posedge clk);
        #1;
        OUT_READY = 1'b0;
        check("release_valid", OUT_VALID, 0);
        check("release_in_ready", IN_READY, 1);
    endtask
    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, IN_READY, 1);
        check({tag, "_out_valid"}, OUT_VALID, 0);
        check({tag, "_result"}, RESULT, 0);
        check({tag, "_zero"}, ZERO, 1);
    endtask
    initial begin
        reset = 1'b1;
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        ALU_CONTROL = 3'd0;
        SRC_A = '0;
        SRC_B = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");
        @(negedge clk);
        reset = 1'b0;
        // reset in the middle of a long shift
        start(3'd5, 32'h1, 32'd20);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async_rst");
        @(posedge clk);
        #1;
        check_reset_state("mid_shift_rst");
        @(negedge clk);
        reset = 1'b0;
        exec(3'd0, 32'h7FFFFFFF, 32'h1, 0);
        exec(3'd1, 32'd5, 32'd5, 0);
        exec(3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 0);
        exec(3'd3, 32'hF0F0F0F0, 32'hFF00FF00, 0);
        exec(3'd4, 32'hF0F0F0F0, 32'hFF00FF00, 0);
        exec(3'd7, 32'h80000000, 32'd4, 0);
        exec(3'd6, 32'h80000000, 32'd4, 0);
        exec(3'd5, 32'h1, 32'h21, 0);
        exec(3'd5, 32'h1, 32'd31, 0);
        exec(3'd7, 32'h80000001, 32'd31, 0);
        exec(3'd5, 32'h1234ABCD, 32'hFFFFFFE0, 0);
        exec(3'd6, 32'h8000F00D, 32'h0, 0);
        exec(3'd7, 32'hDEADBEEF, 32'h40, 0);
        exec(3'd6, 32'h0000FFFF, 32'd16, 0);
        exec(3'd7, 32'h12345678, 32'd3, 10);
        exec(3'd0, 32'hFFFFFFFF, 32'h1, 10);
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            a = (i % 7 == 0) ? 32'h0 : $urandom;
            b = (i % 11 == 0) ? a : $urandom;
            exec(3'($urandom), a, b, int'($urandom_range(0, 3)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
